// File: rtl/mpp_prefetch_if.sv
// Core-side valid/ready fetch port and program-memory bus of the mpp prefetch unit.
// master = prefetch unit, slave = core plus program memory.
interface mpp_prefetch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              ins_valid;
  logic              ins_ready;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_addr;
  logic              program_cs_n;
  logic [ADDR_W-1:0] program_addr;
  logic [DATA_W-1:0] instruction;

  modport master (
    output ins_valid, ins_data, ins_addr, program_cs_n, program_addr,
    input  ins_ready, instruction
  );

  modport slave (
    input  ins_valid, ins_data, ins_addr, program_cs_n, program_addr,
    output ins_ready, instruction
  );
endinterface

// File: rtl/mpp_prefetch.sv
// Instruction prefetch unit: wait-stated program-memory fetches into a DEPTH-entry FIFO.
// Optional fetch statistics counter enabled by defining MPP_PREFETCH_STATS_EN.
module mpp_prefetch #(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 16,
  parameter int          DEPTH       = 4,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
`ifdef MPP_PREFETCH_STATS_EN
  output logic [15:0]       fetch_count,
`endif
  mpp_prefetch_if.master    bus
);

  localparam int              PTR_W     = $clog2(DEPTH);
  localparam int              CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        wait_reg, wait_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic              cs_n_reg, cs_n_next;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] data_mem_reg [DEPTH];
  logic [ADDR_W-1:0] addr_mem_reg [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  // A flush wins over a simultaneous pop: the FIFO is cleared anyway.
  assign pop = (count_reg != '0) && bus.ins_ready && !flush;

  always_comb begin
    state_next    = state_reg;
    wait_next     = wait_reg;
    fetch_pc_next = fetch_pc_reg;
    paddr_next    = paddr_reg;
    cs_n_next     = cs_n_reg;
    push          = 1'b0;
    if (flush) begin
      state_next    = IDLE;
      wait_next     = '0;
      fetch_pc_next = flush_addr;
      cs_n_next     = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          // Only start when there is room, so the capture can never overflow.
          if (count_reg < FULL_CNT) begin
            state_next = ACCESS;
            wait_next  = '0;
            cs_n_next  = 1'b0;
            paddr_next = fetch_pc_reg;
          end
        end
        ACCESS: begin
          if (wait_reg == WAIT_LAST) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
            cs_n_next     = 1'b1;
            wait_next     = '0;
            state_next    = IDLE;
          end else begin
            wait_next = wait_reg + 4'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wait_reg     <= '0;
      fetch_pc_reg <= PC_INIT;
      paddr_reg    <= PC_INIT;
      cs_n_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      wait_reg     <= wait_next;
      fetch_pc_reg <= fetch_pc_next;
      paddr_reg    <= paddr_next;
      cs_n_reg     <= cs_n_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset; count_reg gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_reg[wr_ptr_reg] <= bus.instruction;
      addr_mem_reg[wr_ptr_reg] <= fetch_pc_reg;
    end
  end

  assign bus.ins_valid    = (count_reg != '0);
  assign bus.ins_data     = (count_reg != '0) ? data_mem_reg[rd_ptr_reg] : '0;
  assign bus.ins_addr     = (count_reg != '0) ? addr_mem_reg[rd_ptr_reg] : '0;
  assign bus.program_cs_n = cs_n_reg;
  assign bus.program_addr = paddr_reg;

`ifdef MPP_PREFETCH_STATS_EN
  logic [15:0] fetch_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_reg <= '0;
    end else if (push && (fetch_count_reg != 16'hFFFF)) begin
      fetch_count_reg <= fetch_count_reg + 16'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_mpp_prefetch.sv
// Self-checking bench for mpp_prefetch: directed vector table, corner sequences,
// and a randomized run against a rule-level model of fetch order, bus timing and occupancy.
module tb_mpp_prefetch;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam int WAITC  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_addr = '0;
`ifdef MPP_PREFETCH_STATS_EN
  logic [15:0] fetch_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:65535];

  mpp_prefetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mpp_prefetch #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .WAIT_CYCLES(WAITC), .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .flush_addr (flush_addr),
`ifdef MPP_PREFETCH_STATS_EN
    .fetch_count(fetch_count),
`endif
    .bus        (bus.master)
  );

  assign bus.instruction = mem[bus.program_addr];

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [15:0] exp_addr;
    logic        exp_cs_n;
    logic [15:0] exp_paddr;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic [15:0] a, input logic c, input logic [15:0] pa);
    vec_t t;
    t.ready = r; t.exp_valid = v; t.exp_data = d;
    t.exp_addr = a; t.exp_cs_n = c; t.exp_paddr = pa;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.ins_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.ins_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    if (!bus.ins_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_valid: ins_valid still 0 after %0d cycles, required 1", cycles);
    end
  endtask

  initial begin
    int cyc;
    int falls;
    logic prev_cs;
    // randomized-model state
    logic        cs_model;
    int          low_len;
    int          occ;
    logic [15:0] exp_pc;
    logic [15:0] fetch_next;
    int          ready_pct;

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h07; mem[1] = 8'hC0; mem[2] = 8'h55; mem[3] = 8'h07;
    mem[4] = 8'hC1; mem[5] = 8'h66; mem[6] = 8'h07; mem[7] = 8'h06;
    mem[8] = 8'h00; mem[9] = 8'h0E; mem[10] = 8'h07;
    mem[16'h000E] = 8'h01; mem[16'hFFFF] = 8'hAA;

    vecs[0] = mk(1, 0, 8'h00, 16'h0, 0, 16'h0);
    vecs[1] = mk(1, 0, 8'h00, 16'h0, 0, 16'h0);
    vecs[2] = mk(1, 1, 8'h07, 16'h0, 1, 16'h0);
    vecs[3] = mk(1, 0, 8'h00, 16'h0, 0, 16'h1);
    vecs[4] = mk(1, 0, 8'h00, 16'h0, 0, 16'h1);
    vecs[5] = mk(1, 1, 8'hC0, 16'h1, 1, 16'h1);
    vecs[6] = mk(1, 0, 8'h00, 16'h0, 0, 16'h2);
    vecs[7] = mk(1, 0, 8'h00, 16'h0, 0, 16'h2);
    vecs[8] = mk(1, 1, 8'h55, 16'h2, 1, 16'h2);

    // Reset state
    bus.ins_ready = 1'b0;
    tick();
    check("reset_cs_n", 32'(bus.program_cs_n), 32'd1);
    check("reset_valid", 32'(bus.ins_valid), 32'd0);
    check("reset_data", 32'(bus.ins_data), 32'd0);
    check("reset_addr", 32'(bus.ins_addr), 32'd0);
    check("reset_paddr", 32'(bus.program_addr), 32'd0);

    // 1: streaming after reset release, one row per edge
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.ins_ready = vecs[i].ready;
      tick();
      $display("[TB] vec %0d valid=%0b data=%02h addr=%04h cs_n=%0b paddr=%04h", i,
               bus.ins_valid, bus.ins_data, bus.ins_addr, bus.program_cs_n, bus.program_addr);
      check($sformatf("vec%0d_valid", i), 32'(bus.ins_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 32'(bus.ins_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_addr", i), 32'(bus.ins_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_cs_n", i), 32'(bus.program_cs_n), 32'(vecs[i].exp_cs_n));
      check($sformatf("vec%0d_paddr", i), 32'(bus.program_addr), 32'(vecs[i].exp_paddr));
    end

    // 2: core stalled -> FIFO fills after exactly DEPTH accesses
    do_reset();
    falls = 0;
    prev_cs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (prev_cs && !bus.program_cs_n) falls++;
      prev_cs = bus.program_cs_n;
    end
    $display("[TB] stall: accesses=%0d head=%02h@%04h", falls, bus.ins_data, bus.ins_addr);
    check("full_accesses", 32'(falls), 32'(DEPTH));
    check("full_cs_n", 32'(bus.program_cs_n), 32'd1);
    check("full_head_data", 32'(bus.ins_data), 32'h07);
    bus.ins_ready = 1'b1;
    tick();
    bus.ins_ready = 1'b0;
    check("pop1_head_data", 32'(bus.ins_data), 32'hC0);
    check("pop1_head_addr", 32'(bus.ins_addr), 32'h1);
    check("pop1_cs_n", 32'(bus.program_cs_n), 32'd1);
    tick();
    $display("[TB] refill: cs_n=%0b paddr=%04h", bus.program_cs_n, bus.program_addr);
    check("refill_cs_n", 32'(bus.program_cs_n), 32'd0);
    check("refill_paddr", 32'(bus.program_addr), 32'h4);

    // 3: flush during the second access cycle
    do_reset();
    bus.ins_ready = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    flush_addr = 16'h000E;
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(bus.ins_valid), 32'd0);
    check("flush_cs_n", 32'(bus.program_cs_n), 32'd1);
    wait_valid(cyc);
    $display("[TB] after flush: %02h@%04h", bus.ins_data, bus.ins_addr);
    check("flush_data", 32'(bus.ins_data), 32'h01);
    check("flush_addr", 32'(bus.ins_addr), 32'h000E);

    // 4: address wrap
    flush = 1'b1;
    flush_addr = 16'hFFFF;
    tick();
    flush = 1'b0;
    wait_valid(cyc);
    $display("[TB] wrap word: %02h@%04h", bus.ins_data, bus.ins_addr);
    check("wrap_data0", 32'(bus.ins_data), 32'hAA);
    check("wrap_addr0", 32'(bus.ins_addr), 32'hFFFF);
    tick();
    wait_valid(cyc);
    $display("[TB] wrap word: %02h@%04h", bus.ins_data, bus.ins_addr);
    check("wrap_data1", 32'(bus.ins_data), 32'h07);
    check("wrap_addr1", 32'(bus.ins_addr), 32'h0000);

    // 5: asynchronous reset in the middle of an access
    cyc = 0;
    while (bus.program_cs_n && cyc < 20) begin
      tick();
      cyc++;
    end
    check("mid_access_reached", 32'(bus.program_cs_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cs_n", 32'(bus.program_cs_n), 32'd1);
    check("async_rst_valid", 32'(bus.ins_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_valid(cyc);
    $display("[TB] after reset: %02h@%04h latency=%0d", bus.ins_data, bus.ins_addr, cyc);
    check("rst_refetch_data", 32'(bus.ins_data), 32'h07);
    check("rst_refetch_addr", 32'(bus.ins_addr), 32'h0);
    check("rst_latency", 32'(cyc), 32'(WAITC + 2));

`ifdef MPP_PREFETCH_STATS_EN
    // 6: completed-fetch counter
    do_reset();
    bus.ins_ready = 1'b1;
    falls = 0;
    for (int i = 0; i < 200 && falls < 10; i++) begin
      tick();
      if (bus.ins_valid) falls++;
    end
    $display("[TB] stats: delivered=%0d fetch_count=%0d", falls, fetch_count);
    check("stats_10", 32'(fetch_count), 32'd10);
    tick();
    check("stats_access_open", 32'(bus.program_cs_n), 32'd0);
    flush = 1'b1;
    flush_addr = 16'h0100;
    tick();
    flush = 1'b0;
    check("stats_after_flush", 32'(fetch_count), 32'd10);
    rst_n = 1'b0;
    #1;
    check("stats_reset", 32'(fetch_count), 32'd0);
    tick();
`endif

    // Randomized run against the rule-level model
    do_reset();
    cs_model   = 1'b1;
    low_len    = 0;
    occ        = 0;
    exp_pc     = 16'h0000;
    fetch_next = 16'h0000;
    ready_pct  = 90;
    for (int c = 0; c < 1500; c++) begin
      logic        fl;
      logic [15:0] fa;
      logic        rd;
      logic        pop;
      logic        exp_cs;
      logic        capture;
      if (c % 200 == 0) ready_pct = (c / 200 % 3 == 0) ? 90 : ((c / 200 % 3 == 1) ? 10 : 50);
      fl = ($urandom_range(0, 39) == 0);
      fa = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 65535));
      rd = ($urandom_range(0, 99) < ready_pct);
      pop = bus.ins_valid && rd && !fl;
      if (pop) begin
        $display("[TB] rand pop %02h@%04h", bus.ins_data, bus.ins_addr);
        check("rand_pop_addr", 32'(bus.ins_addr), 32'(exp_pc));
        check("rand_pop_data", 32'(bus.ins_data), 32'(mem[exp_pc]));
        exp_pc = exp_pc + 16'd1;
      end
      if (fl)               exp_cs = 1'b1;
      else if (cs_model)    exp_cs = (occ < DEPTH) ? 1'b0 : 1'b1;
      else                  exp_cs = (low_len < WAITC + 1) ? 1'b0 : 1'b1;
      capture = !fl && !cs_model && (low_len == WAITC + 1);

      flush = fl;
      flush_addr = fa;
      bus.ins_ready = rd;
      tick();

      if (fl) begin
        occ = 0;
        exp_pc = fa;
        fetch_next = fa;
      end else begin
        occ = occ + (capture ? 1 : 0) - (pop ? 1 : 0);
        if (capture) fetch_next = fetch_next + 16'd1;
      end
      low_len = exp_cs ? 0 : (cs_model ? 1 : low_len + 1);
      cs_model = exp_cs;

      check("rand_cs_n", 32'(bus.program_cs_n), 32'(cs_model));
      check("rand_valid", 32'(bus.ins_valid), 32'(occ != 0));
      if (occ == 0) check("rand_empty_data", 32'({bus.ins_data, bus.ins_addr}), 32'd0);
      if (!cs_model && low_len == 1) check("rand_fetch_addr", 32'(bus.program_addr), 32'(fetch_next));
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
